// File: rtl/gray_ptr_sync_dec.sv
// Synchronizes a Gray-coded pointer from a foreign clock domain and decodes it to binary.
// Each accepted change raises a one-cycle strobe with the step size. Multi-bit jumps are flagged and counted.
module gray_ptr_sync_dec #(
    parameter int BIT_WIDTH     = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [BIT_WIDTH-1:0]     gray_in,
    input  logic                     err_clr,
    output logic [BIT_WIDTH-1:0]     bin_data,
    output logic                     bin_valid,
    output logic [BIT_WIDTH-1:0]     bin_step,
    output logic                     gray_err,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

    function automatic logic [BIT_WIDTH-1:0] gray2bin(input logic [BIT_WIDTH-1:0] g);
        logic [BIT_WIDTH-1:0] b;
        b[BIT_WIDTH-1] = g[BIT_WIDTH-1];
        for (int i = BIT_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] c);
        return (c == {ERR_CNT_WIDTH{1'b1}}) ? c : c + 1'b1;
    endfunction

    logic [BIT_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [BIT_WIDTH-1:0] sync_gray;
    logic [BIT_WIDTH-1:0] gray_prev;
    logic [BIT_WIDTH-1:0] gray_diff;
    logic [BIT_WIDTH-1:0] dec_gray;
    logic                 changed;
    logic                 multi_bit;

    // Synchronizer chain: plain flop-to-flop, no logic between stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= gray_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_gray = sync_q[SYNC_STAGES-1];
    assign gray_diff = sync_gray ^ gray_prev;
    assign dec_gray  = gray2bin(sync_gray);
    assign changed   = |gray_diff;
    // Clearing the lowest set bit leaves a nonzero value only if two or more bits differ
    assign multi_bit = |(gray_diff & (gray_diff - 1'b1));

    // Compare / decode stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray_prev <= '0;
            bin_data  <= '0;
            bin_step  <= '0;
            bin_valid <= 1'b0;
            gray_err  <= 1'b0;
            err_cnt   <= '0;
        end else begin
            bin_valid <= changed;
            gray_err  <= multi_bit;
            if (changed) begin
                gray_prev <= sync_gray;
                bin_data  <= dec_gray;
                bin_step  <= dec_gray - bin_data;
            end
            if (multi_bit) begin
                err_cnt <= sat_inc(err_clr ? '0 : err_cnt);
            end else if (err_clr) begin
                err_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_gray_ptr_sync_dec.sv
// Directed bench for gray_ptr_sync_dec with default parameters (4-bit, 2 sync stages, 8-bit counter).
module tb_gray_ptr_sync_dec;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] gray_in = 4'b0000;
    logic       err_clr = 1'b0;
    logic [3:0] bin_data;
    logic       bin_valid;
    logic [3:0] bin_step;
    logic       gray_err;
    logic [7:0] err_cnt;

    int n_vec = 0;
    int n_err = 0;

    gray_ptr_sync_dec #(
        .BIT_WIDTH(4),
        .SYNC_STAGES(2),
        .ERR_CNT_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .gray_in(gray_in),
        .err_clr(err_clr),
        .bin_data(bin_data),
        .bin_valid(bin_valid),
        .bin_step(bin_step),
        .gray_err(gray_err),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_data"},  32'(bin_data),  32'h0);
        chk({tag, "_valid"}, 32'(bin_valid), 32'h0);
        chk({tag, "_step"},  32'(bin_step),  32'h0);
        chk({tag, "_err"},   32'(gray_err),  32'h0);
        chk({tag, "_cnt"},   32'(err_cnt),   32'h0);
    endtask

    task automatic do_reset(input logic [3:0] g);
        gray_in = g;
        rst_n = 1'b0;
        #1;
        chk_zero("rst");
        tick();
        tick();
        chk_zero("rst_hold");
        rst_n = 1'b1;
    endtask

    // Drive a new Gray value and check the pulse lands on the third edge and lasts one cycle
    task automatic apply(input string tag, input logic [3:0] g, input logic [3:0] d,
                         input logic [3:0] st, input logic e, input logic [7:0] c);
        gray_in = g;
        tick();
        chk({tag, "_lat1"}, 32'(bin_valid), 32'h0);
        tick();
        chk({tag, "_lat2"}, 32'(bin_valid), 32'h0);
        tick();
        chk({tag, "_valid"}, 32'(bin_valid), 32'h1);
        chk({tag, "_data"},  32'(bin_data),  32'(d));
        chk({tag, "_step"},  32'(bin_step),  32'(st));
        chk({tag, "_err"},   32'(gray_err),  32'(e));
        chk({tag, "_cnt"},   32'(err_cnt),   32'(c));
        tick();
        chk({tag, "_vdrop"}, 32'(bin_valid), 32'h0);
        chk({tag, "_edrop"}, 32'(gray_err),  32'h0);
        chk({tag, "_hold"},  32'(bin_data),  32'(d));
    endtask

    initial begin
        // 1: reset with 1010 pending, then accepted as a two-bit jump from 0
        do_reset(4'b1010);
        apply("t1", 4'b1010, 4'd12, 4'd12, 1'b1, 8'd1);

        // 2: up-count from a clean reset
        do_reset(4'b0000);
        apply("t2_1", 4'b0001, 4'd1, 4'd1, 1'b0, 8'd0);
        apply("t2_2", 4'b0011, 4'd2, 4'd1, 1'b0, 8'd0);
        apply("t2_3", 4'b0010, 4'd3, 4'd1, 1'b0, 8'd0);

        // 3: walk up to 15, wrap to 0, then decrement
        for (int i = 4; i < 16; i++) begin
            logic [3:0] v;
            v = 4'(i);
            apply("t3_walk", v ^ (v >> 1), v, 4'd1, 1'b0, 8'd0);
        end
        apply("t3_wrap", 4'b0000, 4'd0, 4'd1, 1'b0, 8'd0);
        apply("t3_up",   4'b0001, 4'd1, 4'd1, 1'b0, 8'd0);
        apply("t3_dec",  4'b0000, 4'd0, 4'hF, 1'b0, 8'd0);

        // 4: multi-bit violation, then hold with no further pulses
        apply("t4", 4'b0110, 4'd4, 4'd4, 1'b1, 8'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_quiet_v", 32'(bin_valid), 32'h0);
            chk("t4_quiet_e", 32'(gray_err),  32'h0);
        end

        // 5: 300 back-to-back violations saturate the counter
        for (int i = 0; i < 300; i++) begin
            gray_in = (i % 2 == 0) ? 4'b0000 : 4'b0110;
            tick();
        end
        tick();
        tick();
        tick();
        chk("t5_sat", 32'(err_cnt), 32'd255);
        chk("t5_sat_quiet", 32'(bin_valid), 32'h0);
        gray_in = 4'b0000;
        tick();
        tick();
        chk("t5_pre_clr", 32'(err_cnt), 32'd255);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t5_clr_err_cnt", 32'(err_cnt),  32'd1);
        chk("t5_clr_err_flag", 32'(gray_err), 32'h1);
        chk("t5_clr_err_step", 32'(bin_step), 32'hC);
        tick();
        chk("t5_no_clr_hold", 32'(err_cnt), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t5_clr_alone", 32'(err_cnt), 32'd0);

        // 6: reset mid-stream with 0011 in flight
        do_reset(4'b0000);
        apply("t6_pre", 4'b0001, 4'd1, 4'd1, 1'b0, 8'd0);
        gray_in = 4'b0011;
        tick();
        rst_n = 1'b0;
        #1;
        chk_zero("t6_rst");
        tick();
        rst_n = 1'b1;
        apply("t6_post", 4'b0011, 4'd2, 4'd2, 1'b1, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gray_ptr_sync_dec.md
# gray_ptr_sync_dec

Receive-side counterpart of the team's binary-to-Gray encoder. It samples a Gray-coded pointer or counter produced in another clock domain and passes it through a multi-flop synchronizer. It then decodes the value back to binary and reports each accepted change as a one-cycle strobe with the signed step size. Any sample that violates the single-bit-change Gray property is flagged and counted.

## Interface
- BIT_WIDTH, 4, width of the Gray input and the binary output (≥2)
- SYNC_STAGES, 2, number of synchronizer flops on gray_in (≥2)
- ERR_CNT_WIDTH, 8, width of the saturating error counter
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- gray_in  input  BIT_WIDTH  Gray-coded value from the foreign domain; asynchronous to clk
- err_clr  input  1  synchronous clear of err_cnt
- bin_data  output  BIT_WIDTH  last accepted value, decoded to binary, registered
- bin_valid  output  1  one-cycle pulse when bin_data updates
- bin_step  output  BIT_WIDTH  (new − previous) mod 2^BIT_WIDTH, registered, meaningful while bin_valid=1
- gray_err  output  1  one-cycle pulse when the accepted sample differed from the previous one in more than one bit
- err_cnt  output  ERR_CNT_WIDTH  count of gray_err events, saturating

## Operation
- Synchronizer: a SYNC_STAGES-deep flop chain samples gray_in. The last stage is sync_gray. No logic is allowed between synchronizer flops.
- gray_prev register holds the last accepted Gray value. bin_data holds its binary decode.
- Decode rule: b[MSB]=g[MSB], and b[i]=b[i+1]^g[i] for i from MSB−1 down to 0. This is pure combinational logic on sync_gray, registered into bin_data.
- Each cycle, compute d = popcount(sync_gray ^ gray_prev):
  - d=0: no update. bin_valid=0, gray_err=0. bin_data, bin_step and gray_prev hold.
  - d=1: accept. gray_prev←sync_gray and bin_data←decode(sync_gray). bin_step←decode(sync_gray)−bin_data, modulo 2^BIT_WIDTH. bin_valid=1 for one cycle.
  - d≥2: resynchronize. Perform the same updates as d=1, including bin_valid=1. In addition, gray_err=1 for the same cycle and err_cnt increments.
- err_cnt saturates at 2^ERR_CNT_WIDTH−1 and does not wrap.
- err_clr=1 sets err_cnt to 0 on the next edge. If err_clr and an error occur in the same cycle, err_cnt becomes 1.
- Wrap-around: the transition from max Gray (binary 2^W−1) to 0 is a single-bit change. It is accepted with bin_step=1.
- A decrement gives bin_step = all ones (−1).

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - all synchronizer flops = 0, gray_prev = 0
  - bin_data = 0, bin_step = 0
  - bin_valid = 0, gray_err = 0, err_cnt = 0
- Reset is released synchronously to clk via external logic. The first compare happens on the first edge after release.
- Latency: suppose gray_in is stable before rising edge k. Then sync_gray reflects it after edge k+SYNC_STAGES−1. bin_data, bin_step, bin_valid and gray_err update after edge k+SYNC_STAGES, which is 3 edges with the default setting.
- bin_valid and gray_err are exactly one cycle wide per accepted change.
- Back-to-back changes on consecutive cycles each produce their own pulse. There is no throughput limit.
- Reset mid-operation: every register returns to its reset value immediately. Any in-flight synchronizer contents are discarded. After release, a nonzero gray_in is treated as a change from 0.
- No output has a combinational path from any input.

## Test plan
All scenarios use BIT_WIDTH=4, SYNC_STAGES=2, ERR_CNT_WIDTH=8.

1. Reset: hold rst_n=0 while gray_in=4'b1010 → all outputs 0. After release, bin_valid pulses 3 edges later with bin_data=12 (0xC), gray_err=1 (d=2) and err_cnt=1.
2. Up-count: from the reset state, drive gray_in = 0001, 0011, 0010, each held 4 cycles → bin_data = 1, 2, 3. Each bin_step=1 with a one-cycle bin_valid, first pulse 3 edges after the first change, gray_err stays 0.
3. Wrap and decrement: drive gray 1000 (bin 15), then 0000 → bin_data=0, bin_step=1. Then drive 0001 followed by 0000 → bin_data=0, bin_step=4'hF, no gray_err.
4. Multi-bit violation: from gray 0000, drive 0110 → bin_data=4, bin_step=4, bin_valid=1 and gray_err=1 in the same cycle, err_cnt=1. Holding 0110 further produces no more pulses.
5. Counter: force 300 violations → err_cnt saturates at 255. Then err_clr in the same cycle as a violation → err_cnt=1. err_clr alone → 0.
6. Mid-stream reset: assert rst_n=0 for 1 cycle during the up-count with gray_in=0011 → outputs are 0 immediately. After release, bin_valid fires with bin_data=2, gray_err=1.
